// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS boot-and-run sequencer: state encoding,
// default memory depth and the asserted level of the core reset.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  localparam int DEFAULT_INSTR_DEPTH = 200;

  localparam logic CORE_RESET_ACTIVE = 1'b1;

endpackage

// File: rtl/mips_program_sequencer_if.sv
// Program-load stream from the host plus the instruction-memory write port
// that the sequencer drives into the single-cycle MIPS core.
interface mips_program_sequencer_if;

  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        instruction_Write_en;
  logic [31:0] Write_address;
  logic [31:0] Write_instruction;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, instruction_Write_en, Write_address, Write_instruction
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, instruction_Write_en, Write_address, Write_instruction
  );

endinterface

// File: rtl/mips_run_counter.sv
// Up-counter with synchronous clear/enable and an equality compare against a
// caller-supplied limit; used for both the reset-hold delay and the run count.
module mips_run_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit);

endmodule

// File: rtl/mips_program_sequencer.sv
// Loads a host program into the MIPS instruction memory while holding the core
// in reset, then releases it for a bounded number of cycles.
module mips_program_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_DEPTH  = DEFAULT_INSTR_DEPTH,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_W-1:0]            run_budget,
  input  logic                        stop,
  mips_program_sequencer_if.slave     bus,
  output logic                        core_reset,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [CNT_W-1:0]            cycles_run
);

  localparam int AW = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(INSTR_DEPTH - 1);
  localparam logic [CNT_W-1:0] CLR_LIMIT = CNT_W'(RESET_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              error_q, error_d;
  logic              we_q, we_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_limit;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_at_limit;
  logic              xfer;

  // One counter times the reset hold in CLEAR, then restarts from zero to count RUN cycles.
  assign cnt_limit = (state_q == S_CLEAR) ? CLR_LIMIT : (budget_q - CNT_W'(1));

  mips_run_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .limit    (cnt_limit),
    .count    (cnt_value),
    .at_limit (cnt_at_limit)
  );

  assign xfer = (state_q == S_LOAD) && bus.load_valid;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    budget_d = budget_q;
    error_d  = error_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          wcnt_d   = '0;
          error_d  = 1'b0;
          budget_d = run_budget;
          cnt_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = {{(32 - AW){1'b0}}, wcnt_q};
          wdata_d = bus.load_data;
          wcnt_d  = wcnt_q + AW'(1);
          if (bus.load_last) begin
            state_d = S_CLEAR;
            cnt_clr = 1'b1;
          end else if (wcnt_q == LAST_ADDR) begin
            // Memory is full and the program has not ended: abandon the session.
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        if (cnt_at_limit) begin
          cnt_clr = 1'b1;
          state_d = (budget_q == '0) ? S_DONE : S_RUN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (cnt_at_limit || stop) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      budget_q <= '0;
      error_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      budget_q <= budget_d;
      error_q  <= error_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.load_ready           = (state_q == S_LOAD);
  assign bus.instruction_Write_en = we_q;
  assign bus.Write_address        = waddr_q;
  assign bus.Write_instruction    = wdata_q;

  assign core_reset = (state_q == S_RUN) ? ~CORE_RESET_ACTIVE : CORE_RESET_ACTIVE;
  assign busy       = (state_q == S_LOAD) || (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  // While CLEAR borrows the counter its value is a delay, not a run count.
  assign cycles_run = (state_q == S_CLEAR) ? '0 : cnt_value;

endmodule

// File: doc/mips_program_sequencer.md
# mips_program_sequencer

Boot-and-run controller for the single-cycle MIPS core. Accepts a program from a host over a valid/ready stream and writes it word by word into the core's instruction memory through the `instruction_Write_en` / `Write_address` / `Write_instruction` port. It holds the core in reset while loading, then releases the core for a bounded number of cycles. It also reports completion, cycles executed and load overflow.

## Interface
- `INSTR_DEPTH`, 200: instruction memory depth in words; maximum program length.
- `RESET_CYCLES`, 2: cycles `core_reset` stays asserted after the last write, before RUN.
- `CNT_W`, 16: width of the run budget and cycle counter.

- `clk` in 1: single clock. Rising-edge only.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse. Begins a load/run session. Honoured only in IDLE or DONE.
- `run_budget` in CNT_W: maximum RUN cycles. Sampled on the accepted `start`.
- `stop` in 1: forces early exit from RUN.
- `load_valid` in 1: host has a program word.
- `load_data` in 32: program word.
- `load_last` in 1: qualifies the final word.
- `load_ready` out 1: sequencer accepts a word. A transfer occurs when `load_valid & load_ready` at a rising edge.
- `instruction_Write_en` out 1: instruction memory write enable to the core.
- `Write_address` out 32: instruction memory word address.
- `Write_instruction` out 32: instruction word to write.
- `core_reset` out 1: reset to the core datapath (PC, register file, data memory).
- `busy` out 1: high in LOAD, CLEAR and RUN.
- `done` out 1: high in DONE.
- `error` out 1: overflow flag. Valid while `done`.
- `cycles_run` out CNT_W: number of RUN cycles in the last session.

## Operation
- States: IDLE, LOAD, CLEAR, RUN, DONE. Encoding is in the shared package.
- IDLE:
  - `start` → LOAD.
  - On entry to LOAD: clear the word counter, `error` and `cycles_run`; latch `run_budget`.
- LOAD:
  - `load_ready` = 1.
  - Each transfer writes `load_data` at address = word counter, then increments the counter.
  - Transfer with `load_last` → CLEAR.
  - Transfer at counter = INSTR_DEPTH-1 without `load_last` → `error` set, go to DONE. RUN is skipped and the core stays in reset.
  - `load_valid` without a transfer does not advance the counter.
- CLEAR:
  - Hold `core_reset` for RESET_CYCLES cycles.
  - Then → RUN, or → DONE directly if the latched budget is 0.
- RUN:
  - `core_reset` = 0.
  - `cycles_run` increments every cycle.
  - Exit to DONE when `cycles_run` reaches the budget, or on `stop`.
  - If `stop` coincides with budget exhaustion, the result is the same: DONE, count = budget.
- DONE:
  - `done` = 1 and `core_reset` = 1. `cycles_run` and `error` are held.
  - `start` → LOAD (new session).
- `core_reset` = 1 in every state except RUN.
- `start` in LOAD, CLEAR or RUN is ignored.
- `load_valid` outside LOAD is ignored, since `load_ready` = 0.
- Write width rule: `Write_address` is the word counter zero-extended to 32 bits. The counter width is clog2(INSTR_DEPTH).

## Timing
- Reset values:
  - State = IDLE.
  - `load_ready`, `instruction_Write_en`, `busy`, `done`, `error` = 0.
  - `Write_address`, `Write_instruction`, `cycles_run` = 0.
  - `core_reset` = 1.
- Write outputs are registered. A transfer at edge N drives `instruction_Write_en`=1, address and data during cycle N+1. Memory captures at edge N+2.
- `instruction_Write_en` is a one-cycle pulse per transfer. Back-to-back transfers give back-to-back pulses.
- CLEAR is entered no earlier than the cycle the last write is presented, so the last word commits before `core_reset` falls. With RESET_CYCLES ≥ 1 this holds.
- `load_ready`, `busy` and `done` are decoded from the state register: Moore, no combinational path from inputs.
- `start` → `load_ready` = 1 the next cycle.
- Exactly `budget` cycles have `core_reset` = 0.
- `stop` seen at edge N ends RUN at that edge.
- `reset` mid-session: next edge returns to IDLE with reset values. Instruction memory contents are not cleared, since that memory has no reset.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum/localparams (IDLE=0, LOAD=1, CLEAR=2, RUN=3, DONE=4);
  - default INSTR_DEPTH;
  - the reset constant for `core_reset`.
- One sub-module, `mips_run_counter`: a CNT_W up-counter with synchronous clear/enable and a terminal-compare output. It is reused for the CLEAR delay and the RUN count.
- The top-level sequencer instantiates the FSM and sits beside `Single_Cycle_MIPS`, driving its `reset`, `instruction_Write_en`, `Write_address` and `Write_instruction`.

## Test plan
- Reset then idle 5 cycles → `core_reset`=1, `load_ready`=0, `done`=0, `Write_address`=0.
- `start` with budget=10; 3 words 0x08000000, 0x18220005, 0x28000000, the last with `load_last` → three `instruction_Write_en` pulses at addresses 0, 1, 2 with matching data. `core_reset` falls 2 cycles after CLEAR entry and stays low 10 cycles. `done`=1, `cycles_run`=10.
- Host deasserts `load_valid` for 3 cycles between words → no extra write pulses, addresses stay contiguous.
- 200 words with no `load_last` → `error`=1, DONE, `core_reset` never deasserted, `cycles_run`=0.
- budget=100, `stop` asserted in the 7th RUN cycle → `done`=1, `cycles_run`=7.
- Assert `reset` in the middle of RUN, then a new `start` with budget=0 and 1 word → IDLE reached after reset; second session goes LOAD → CLEAR → DONE with `cycles_run`=0.
